// File: rtl/uart_tx_pkg.sv
// Shared state encoding and constants for the RAM-draining UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } uart_tx_state_type;

  localparam int UART_CLK_DIV_115200 = 434;
  localparam int UART_DATA_BITS      = 8;
  localparam int UART_BIT_IDX_W      = $clog2(UART_DATA_BITS);

  // States in which a frame is on the line and the bit timer runs.
  function automatic logic is_frame_state(input uart_tx_state_type s);
    return (s == S_START) || (s == S_DATA) || (s == S_STOP);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit timer: counts 0..CLK_DIV-1 while enabled and flags the last cycle of each bit.
module uart_baud_tick #(
  parameter int CLK_DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == CNT_LAST) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ram_streamer.sv
// Drains NUM_BYTES from a registered DP-RAM, starting at address 0, onto an 8N1 UART line.
module uart_tx_ram_streamer
  import uart_tx_pkg::*;
#(
  parameter int CLK_DIV   = UART_CLK_DIV_115200,
  parameter int NUM_BYTES = 512,
  parameter int ADDR_W    = 9
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  output logic [ADDR_W-1:0] RAM_address,
  input  logic [7:0]        RAM_read_data,
  output logic              UART_TX_O,
  output logic              UART_tx_clock_enable,
  output logic              UART_tx_busy,
  output logic              UART_tx_done
);

  localparam int BYTE_CNT_W = $clog2(NUM_BYTES + 1);
  localparam logic [BYTE_CNT_W-1:0]     LAST_BYTE = BYTE_CNT_W'(NUM_BYTES - 1);
  localparam logic [UART_BIT_IDX_W-1:0] LAST_BIT  = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

  uart_tx_state_type state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [BYTE_CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      bit_tick;
  logic                      last_byte;

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .clk    (Clock),
    .rst_n  (Resetn),
    .clear  (state_q == S_LOAD),
    .enable (is_frame_state(state_q)),
    .tick   (bit_tick)
  );

  assign last_byte = (byte_cnt_q == LAST_BYTE);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          addr_d     = '0;
          byte_cnt_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = RAM_read_data;
        state_d = S_START;
      end
      S_START: begin
        if (bit_tick) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d = S_STOP;
            // Advance as the stop bit begins so the next byte is read well before it ends.
            if (!last_byte) begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end else begin
            bit_idx_d = bit_idx_q + UART_BIT_IDX_W'(1);
          end
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          if (last_byte) begin
            state_d = S_DONE;
          end else begin
            shift_d    = RAM_read_data;
            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
            state_d    = S_START;
          end
        end
      end
      S_DONE: begin
        if (Start) begin
          addr_d     = '0;
          byte_cnt_d = '0;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line and status are registered from the next state so they align with state_q.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign RAM_address          = addr_q;
  assign UART_TX_O            = tx_q;
  assign UART_tx_clock_enable = bit_tick;
  assign UART_tx_busy         = busy_q;
  assign UART_tx_done         = done_q;

endmodule

// File: doc/uart_tx_ram_streamer.md
Name: uart_tx_ram_streamer

Overview:
Reads a block of bytes from the embedded dual-port RAM, starting at address 0, and serialises each byte onto the UART TX line as 8N1 at 115.2 kbaud. It is the downstream stage of the UART receive path: the receiver fills the DP-RAM, and this block drains the RAM back to the host. It raises a done flag after the stop bit of the last byte completes, which the system bench uses to end simulation.

Parameters:
CLK_DIV, 434, Clock cycles per UART bit (50 MHz / 115.2 kbaud; 434 × 20 ns = 8.68 us).
NUM_BYTES, 512, Number of bytes to transmit per run.
ADDR_W, 9, RAM address width; NUM_BYTES ≤ 2^ADDR_W.

Ports:
Clock  in  1  50 MHz system clock.
Resetn  in  1  Asynchronous active-low reset.
Start  in  1  Run request, level or pulse; sampled only in S_IDLE and S_DONE.
RAM_address  out  ADDR_W  Read address to the DP-RAM port B.
RAM_read_data  in  8  DP-RAM read data, valid 1 cycle after RAM_address changes (registered RAM).
UART_TX_O  out  1  Serial line; idle high.
UART_tx_clock_enable  out  1  One-cycle pulse at each bit boundary while a frame is in progress.
UART_tx_busy  out  1  High from leaving S_IDLE until entering S_DONE.
UART_tx_done  out  1  High in S_DONE; held until the next Start.

Behaviour:
- Reset values: UART_TX_O=1, RAM_address=0, busy=0, done=0, clock_enable=0. Internal state is S_IDLE with all counters at 0. Reset asserted mid-frame forces the line high immediately and abandons the run.
- States and transitions:
  - S_IDLE: Start=1 → S_FETCH. RAM_address stays 0.
  - S_FETCH: one wait cycle for RAM latency, then → S_LOAD.
  - S_LOAD: latch RAM_read_data into tx_shift, clear the bit timer, then → S_START.
  - S_START: UART_TX_O=0 for exactly CLK_DIV cycles, then → S_DATA with bit_idx=0.
  - S_DATA: UART_TX_O=tx_shift[bit_idx], LSB first. Each bit lasts CLK_DIV cycles. After bit 7 → S_STOP.
  - S_STOP: UART_TX_O=1 for CLK_DIV cycles. On the first cycle of S_STOP, increment RAM_address; read data is ready before the stop bit ends. At stop end: if byte_cnt==NUM_BYTES-1 → S_DONE, else latch RAM_read_data into tx_shift and → S_START directly.
  - S_DONE: done=1, line high. Start=1 → reset RAM_address and byte_cnt to 0, clear done, → S_FETCH.
- Frame timing:
  - Each frame is exactly 10×CLK_DIV cycles.
  - There is no idle gap between consecutive frames.
  - First start bit begins 2 cycles after Start is sampled.
- Bit timer: counts 0..CLK_DIV-1 and wraps. UART_tx_clock_enable pulses in the cycle the timer equals CLK_DIV-1, only in START, DATA and STOP. Timer width is $clog2(CLK_DIV).
- Counters:
  - byte_cnt is $clog2(NUM_BYTES+1) bits wide and does not wrap within a run.
  - RAM_address wraps modulo 2^ADDR_W. It is never advanced past NUM_BYTES-1 in use.
- Start held high through a run is ignored until S_DONE. While in S_DONE, a held Start immediately begins a new run.
- UART_TX_O is driven from a flip-flop, so the line is glitch-free.

Decomposition:
- Package uart_tx_pkg:
  - enum uart_tx_state_type {S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_STOP, S_DONE}.
  - Constant UART_CLK_DIV_115200 = 434.
  - Constant UART_DATA_BITS = 8.
- One sub-module, uart_baud_tick: a parameterised bit timer with a synchronous clear and a tick output. The FSM, shift register and address counter remain in the top module.

Test Plan:
1. Reset mid-frame: CLK_DIV=8, NUM_BYTES=4. Assert Resetn=0 during bit 3 → UART_TX_O=1 within the same cycle; busy=0, done=0, RAM_address=0. After release, the line stays idle with no Start.
2. Single byte: CLK_DIV=8, NUM_BYTES=1, RAM[0]=8'h55, one-cycle Start pulse → line low 8 cycles, then 1,0,1,0,1,0,1,0 (8 cycles each), then high 8 cycles. done rises exactly 82 cycles after Start is sampled.
3. Back-to-back frames: CLK_DIV=8, NUM_BYTES=4, RAM = 8'h00, 8'hFF, 8'hA5, 8'h01.
   - A bench sampler at mid-bit recovers 00, FF, A5, 01 with no frame errors.
   - Each stop bit is followed immediately by the next start bit (zero gap).
   - RAM_address sequence is 0,1,2,3.
4. Ignored Start: CLK_DIV=8, NUM_BYTES=4. Start held high through the whole run → exactly 4 frames, then done=1 for one cycle. A new run begins on the next cycle with RAM_address=0.
5. Default parameters: CLK_DIV=434, NUM_BYTES=512, RAM[i]=i[7:0].
   - Bit period is 8.68 us.
   - Total run is 512×4340 = 2,222,080 cycles from first start-bit edge to done.
   - Received bytes are 00..FF twice.
6. clock_enable count: CLK_DIV=8, NUM_BYTES=2 → exactly 20 UART_tx_clock_enable pulses, spaced 8 cycles apart, with none in S_IDLE, S_FETCH, S_LOAD or S_DONE.
